// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LS   = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int unsigned DMEM_ADDR_W       = 16;
  localparam int unsigned DMEM_DATA_W       = 32;
  localparam int unsigned DMEM_MAX_WAIT_DEF = 4;

endpackage

// File: rtl/dmem_wait_ctr.sv
// Saturating starvation counter for the DMA requester; expired once the
// count reaches MAX_WAIT consecutive denied cycles.
module dmem_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (32'(cnt_q) >= MAX_WAIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: EX load/store has priority, DMA gets a
// bounded wait; read data returns one cycle after the grant to its owner.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_stall,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_w,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  logic              expired;
  logic              ls_win;
  logic              dma_win;
  owner_t            rd_owner_q;
  owner_t            rd_owner_d;
  logic [ADDR_W-1:0] mem_a_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  dmem_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (dma_req & ~dma_win),
    .clr     (dma_win | ~dma_req),
    .expired (expired)
  );

  // Grants are gated by rst_n so nothing reaches the memory during reset.
  always_comb begin
    ls_win  = 1'b0;
    dma_win = 1'b0;
    if (rst_n) begin
      if (dma_req && expired) begin
        dma_win = 1'b1;
      end else if (ls_req) begin
        ls_win = 1'b1;
      end else if (dma_req) begin
        dma_win = 1'b1;
      end
    end
  end

  always_comb begin
    mem_a      = mem_a_q;
    mem_w      = 1'b0;
    mem_d      = '0;
    rd_owner_d = OWN_NONE;
    if (ls_win) begin
      mem_a      = ls_addr;
      mem_w      = ls_we;
      mem_d      = ls_wdata;
      rd_owner_d = ls_we ? OWN_NONE : OWN_LS;
    end else if (dma_win) begin
      mem_a      = dma_addr;
      mem_w      = dma_we;
      mem_d      = dma_wdata;
      rd_owner_d = dma_we ? OWN_NONE : OWN_DMA;
    end
  end

  assign ls_gnt   = ls_win;
  assign dma_gnt  = dma_win;
  assign ls_stall = ls_req & ~ls_win;

  // Return path: the owner sees mem_q directly, the other side holds.
  assign ls_rvalid  = (rd_owner_q == OWN_LS);
  assign dma_rvalid = (rd_owner_q == OWN_DMA);
  assign ls_rdata   = ls_rvalid  ? mem_q : ls_rdata_q;
  assign dma_rdata  = dma_rvalid ? mem_q : dma_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q  <= OWN_NONE;
      mem_a_q     <= '0;
      ls_rdata_q  <= '0;
      dma_rdata_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      mem_a_q     <= mem_a;
      ls_rdata_q  <= ls_rdata;
      dma_rdata_q <= dma_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32x64K synchronous RAM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_req, ls_we, dma_req, dma_we;
  logic [15:0] ls_addr, dma_addr;
  logic [31:0] ls_wdata, dma_wdata;
  logic        ls_gnt, ls_stall, ls_rvalid, dma_gnt, dma_rvalid, mem_w;
  logic [31:0] ls_rdata, dma_rdata, mem_d, mem_q;
  logic [15:0] mem_a;

  logic [31:0] mem [0:65535];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w) mem[mem_a] <= mem_d;
    mem_q <= mem[mem_a];
  end

  dmem_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_stall   (ls_stall),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_a      (mem_a),
    .mem_w      (mem_w),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  typedef struct {
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        e_ls_gnt;
    logic        e_dma_gnt;
    logic        e_mem_w;
    logic [15:0] e_mem_a;
    logic        e_ls_rv;
    logic [31:0] e_ls_rd;
    logic        e_dma_rv;
    logic [31:0] e_dma_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic lr, logic lw, logic [15:0] la, logic [31:0] ld,
                              logic dr, logic dw, logic [15:0] da, logic [31:0] dd,
                              logic elg, logic edg, logic emw, logic [15:0] ema,
                              logic elv, logic [31:0] eld, logic edv, logic [31:0] edd);
    vec_t v;
    v.ls_req = lr;  v.ls_we = lw;  v.ls_addr = la;  v.ls_wdata = ld;
    v.dma_req = dr; v.dma_we = dw; v.dma_addr = da; v.dma_wdata = dd;
    v.e_ls_gnt = elg; v.e_dma_gnt = edg; v.e_mem_w = emw; v.e_mem_a = ema;
    v.e_ls_rv = elv;  v.e_ls_rd = eld;   v.e_dma_rv = edv; v.e_dma_rd = edd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic lr, input logic lw, input logic [15:0] la, input logic [31:0] ld,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [31:0] dd);
    ls_req = lr;  ls_we = lw;  ls_addr = la;  ls_wdata = ld;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 16'h0003, 32'hFFFF_FFFF, 1'b1, 1'b1, 16'h0004, 32'hFFFF_FFFF);
    #3;
    chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("rst_mem_w", 32'(mem_w), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_rvalid", {30'd0, ls_rvalid, dma_rvalid}, 32'd0);
    chk("rst_rdata", ls_rdata | dma_rdata, 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //          ls: req we addr      wdata          dma: req we addr     wdata
    //          exp: lgnt dgnt memw mem_a    lrv ls_rdata      drv dma_rdata
    vecs.push_back(mk(0,0,16'h0000,32'h0, 0,0,16'h0000,32'h0, 0,0,0,16'h0000, 0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,1,16'h0010,32'hDEADBEEF, 0,0,16'h0,32'h0, 1,0,1,16'h0010, 0,32'h0,     0,32'h0));
    vecs.push_back(mk(1,0,16'h0010,32'h0, 0,0,16'h0,32'h0, 1,0,0,16'h0010, 0,32'h0,            0,32'h0));
    vecs.push_back(mk(0,0,16'h0000,32'h0, 0,0,16'h0,32'h0, 0,0,0,16'h0010, 1,32'hDEADBEEF,     0,32'h0));
    vecs.push_back(mk(1,1,16'h0001,32'h11, 0,0,16'h0,32'h0, 1,0,1,16'h0001, 0,32'hDEADBEEF,    0,32'h0));
    vecs.push_back(mk(0,0,16'h0000,32'h0, 1,1,16'h0002,32'h22, 0,1,1,16'h0002, 0,32'hDEADBEEF, 0,32'h0));
    vecs.push_back(mk(1,0,16'h0001,32'h0, 1,0,16'h0002,32'h0, 1,0,0,16'h0001, 0,32'hDEADBEEF,  0,32'h0));
    vecs.push_back(mk(0,0,16'h0000,32'h0, 1,0,16'h0002,32'h0, 0,1,0,16'h0002, 1,32'h11,        0,32'h0));
    vecs.push_back(mk(0,0,16'h0000,32'h0, 0,0,16'h0,32'h0, 0,0,0,16'h0002, 0,32'h11,           1,32'h22));
    vecs.push_back(mk(0,0,16'h0000,32'h0, 1,1,16'hFFFF,32'h5A5A5A5A, 0,1,1,16'hFFFF, 0,32'h11, 0,32'h22));
    vecs.push_back(mk(1,0,16'hFFFF,32'h0, 0,0,16'h0,32'h0, 1,0,0,16'hFFFF, 0,32'h11,           0,32'h22));
    vecs.push_back(mk(0,0,16'h0000,32'h0, 0,0,16'h0,32'h0, 0,0,0,16'hFFFF, 1,32'h5A5A5A5A,     0,32'h22));
    for (int unsigned k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,16'h0000,32'h0, 0,0,16'h0,32'h0, 0,0,0,16'hFFFF, 0,32'h5A5A5A5A, 0,32'h22));

    foreach (vecs[i]) begin
      drive(vecs[i].ls_req, vecs[i].ls_we, vecs[i].ls_addr, vecs[i].ls_wdata,
            vecs[i].dma_req, vecs[i].dma_we, vecs[i].dma_addr, vecs[i].dma_wdata);
      @(negedge clk);
      chk($sformatf("v%0d_ls_gnt", i),    32'(ls_gnt),     32'(vecs[i].e_ls_gnt));
      chk($sformatf("v%0d_dma_gnt", i),   32'(dma_gnt),    32'(vecs[i].e_dma_gnt));
      chk($sformatf("v%0d_ls_stall", i),  32'(ls_stall),   32'(vecs[i].ls_req & ~vecs[i].e_ls_gnt));
      chk($sformatf("v%0d_mem_w", i),     32'(mem_w),      32'(vecs[i].e_mem_w));
      chk($sformatf("v%0d_mem_a", i),     32'(mem_a),      32'(vecs[i].e_mem_a));
      chk($sformatf("v%0d_ls_rvalid", i), 32'(ls_rvalid),  32'(vecs[i].e_ls_rv));
      chk($sformatf("v%0d_ls_rdata", i),  ls_rdata,        vecs[i].e_ls_rd);
      chk($sformatf("v%0d_dma_rvalid", i),32'(dma_rvalid), 32'(vecs[i].e_dma_rv));
      chk($sformatf("v%0d_dma_rdata", i), dma_rdata,       vecs[i].e_dma_rd);
      @(posedge clk); #1;
    end
    chk("idle_wait_cnt", 32'(u_dut.u_wait_ctr.cnt_q), 32'd0);

    // Continuous LS loads with DMA held: DMA must break through on cycles 4 and 9.
    drive(1'b1, 1'b0, 16'h0001, '0, 1'b1, 1'b0, 16'h0002, '0);
    for (int c = 0; c < 12; c++) begin
      logic dwin, prev_dwin;
      dwin      = (c == 4) || (c == 9);
      prev_dwin = (c == 5) || (c == 10);
      @(negedge clk);
      chk($sformatf("starve%0d_dma_gnt", c),  32'(dma_gnt),  32'(dwin));
      chk($sformatf("starve%0d_ls_gnt", c),   32'(ls_gnt),   32'(!dwin));
      chk($sformatf("starve%0d_ls_stall", c), 32'(ls_stall), 32'(dwin));
      chk($sformatf("starve%0d_wait_cnt", c), 32'(u_dut.u_wait_ctr.cnt_q), 32'(c % 5));
      if (c > 0) begin
        chk($sformatf("starve%0d_ls_rvalid", c),  32'(ls_rvalid),  32'(!prev_dwin));
        chk($sformatf("starve%0d_dma_rvalid", c), 32'(dma_rvalid), 32'(prev_dwin));
        chk($sformatf("starve%0d_ls_rdata", c),   ls_rdata,  32'h11);
        chk($sformatf("starve%0d_dma_rdata", c),  dma_rdata, 32'h22);
      end
      @(posedge clk); #1;
    end

    // Reset pulsed between a load grant and its return edge.
    drive(1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rstmid_ls_gnt", 32'(ls_gnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_ls_gnt_forced", 32'(ls_gnt), 32'd0);
    chk("rstmid_mem_w", 32'(mem_w), 32'd0);
    chk("rstmid_mem_a", 32'(mem_a), 32'd0);
    chk("rstmid_ls_rdata", ls_rdata, 32'd0);
    chk("rstmid_dma_rdata", dma_rdata, 32'd0);
    chk("rstmid_wait_cnt", 32'(u_dut.u_wait_ctr.cnt_q), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstpost_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rstpost_dma_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rstpost_mem_w", 32'(mem_w), 32'd0);
    chk("rstpost_ls_rdata", ls_rdata, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rstpost_first_gnt", 32'(ls_gnt), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rstpost_rvalid", 32'(ls_rvalid), 32'd1);
    chk("rstpost_rdata", ls_rdata, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port (32-bit × 64K words, `DP_mem32x64k`) between the EX-stage load/store path and a DMA/debug requester. At most one access is issued per cycle. The EX path has priority; a bounded-wait counter guarantees DMA forward progress. Read data is returned one cycle later to the original requester. The block sits between EX and the data memory and drives the memory's `A/W/D` pins directly.

## Interface
- `ADDR_W`, 16, word address width into data memory
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, consecutive DMA-denied cycles after which DMA wins the next cycle (1..15)

- `clk` in 1 — system clock, all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `ls_req` in 1 — EX load/store request; held with payload until `ls_gnt`
- `ls_we` in 1 — 1 = store, 0 = load
- `ls_addr` in ADDR_W — word address (base+offset already truncated upstream)
- `ls_wdata` in DATA_W — store data
- `ls_gnt` out 1 — request accepted this cycle
- `ls_stall` out 1 — `ls_req & ~ls_gnt`; freezes EX
- `ls_rvalid` out 1 — load data valid
- `ls_rdata` out DATA_W — load data
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata` — same semantics as the `ls_*` equivalents, for the DMA requester
- `mem_a` out ADDR_W — memory address
- `mem_w` out 1 — memory write enable
- `mem_d` out DATA_W — memory write data
- `mem_q` in DATA_W — memory read data, valid the cycle after the address

## Operation
- Grant logic is combinational from `req` and state. `ls_gnt`, `dma_gnt` and `mem_w` are forced 0 while `rst_n` = 0.
- Arbitration per cycle:
  - DMA wins if `dma_req` and `wait_cnt >= MAX_WAIT`.
  - Otherwise LS wins if `ls_req`.
  - Otherwise DMA wins if `dma_req`.
  - Otherwise no grant.
- Exactly one grant or none per cycle. `mem_a/mem_w/mem_d` are muxed from the winner. With no grant, `mem_w` = 0 and `mem_a` holds its last value (no spurious write).
- `wait_cnt` (4 bits):
  - Clears when DMA is granted or `dma_req` = 0.
  - Increments, saturating at 15, when `dma_req` is high and DMA is not granted.
- Read return:
  - Registered `rd_owner` ∈ {NONE, LS, DMA} is set to the winner when the winner's `we` = 0, else to NONE.
  - Next cycle, `<owner>_rvalid` = 1 and `<owner>_rdata` = `mem_q`.
  - The non-owner's `rdata` holds its previous value.
- Writes produce no `rvalid`. Write commits at the grant edge.
- Read-after-write to the same address on consecutive grants returns the new data.
- A requester may re-request in the cycle its `rvalid` is high; back-to-back reads sustain 1 access/cycle.

## Timing
- Reset values: `rd_owner` = NONE, `wait_cnt` = 0, `ls_rvalid` = `dma_rvalid` = 0, `ls_rdata` = `dma_rdata` = 0, `mem_a` = 0.
- Load latency: grant at cycle N, `rvalid`/`rdata` at cycle N+1.
- Store latency: 0 extra cycles; `ls_stall` drops in the grant cycle.
- Simultaneous requests, `wait_cnt` < MAX_WAIT: LS granted, DMA stalls, `wait_cnt` increments.
- With continuous LS traffic and `dma_req` held, DMA is granted in the cycle where `wait_cnt` = MAX_WAIT, i.e. every MAX_WAIT+1 cycles.
- Reset asserted mid-read: the pending `rvalid` is dropped. After deassertion there is no stale `rvalid` and the first grant is evaluated in the first `clk` edge-cycle.
- Requester drops `req` before grant: legal. No access issued, no state change except `wait_cnt` clear (DMA).

## Structure
- Package `dmem_arb_pkg`:
  - `owner_t` enum {OWN_NONE, OWN_LS, OWN_DMA}
  - `DMEM_ADDR_W` = 16, `DMEM_DATA_W` = 32
  - `DMEM_MAX_WAIT_DEF` = 4
- One sub-module: `dmem_wait_ctr`, the saturating starvation counter with `inc`/`clr` inputs and a `expired` (cnt >= MAX_WAIT) output.
- Everything else (grant mux, `rd_owner` register, return demux) lives in `dmem_arbiter`.

## Test plan
- LS store 0xDEADBEEF to addr 0x0010, then LS load 0x0010 → `ls_gnt` both cycles, `ls_rvalid` = 1 one cycle after the load grant with `ls_rdata` = 0xDEADBEEF, `dma_rvalid` = 0.
- LS and DMA load simultaneously (LS 0x0001, DMA 0x0002, mem preloaded 0x11/0x22) → LS granted first with `ls_rdata` = 0x11, DMA granted next cycle with `dma_rdata` = 0x22 a cycle later.
- LS requests every cycle for 12 cycles, DMA held, MAX_WAIT = 4 → DMA granted on cycles 4 and 9 (0-based), `ls_stall` = 1 exactly on those cycles.
- DMA store 0x5A5A5A5A to 0xFFFF, then LS load 0xFFFF next cycle → `ls_rdata` = 0x5A5A5A5A.
- LS load granted, `rst_n` pulsed low before the next edge → no `ls_rvalid` after reset; all outputs at reset values; `mem_w` = 0 throughout.
- No requests for 5 cycles → `mem_w` = 0, no `rvalid`, `wait_cnt` = 0.
